// File: rtl/median_filter_pkg.sv
// Shared types for the 3x3 streaming median filter: pixel width, pixel and column types.
package median_filter_pkg;
  localparam int PIX_W = 5;
  localparam int ROWS  = 3;
  localparam int COLS  = 3;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [ROWS-1:0] col_t;
endpackage

// File: rtl/median_filter_if.sv
// Column-in / median-out stream between the column reader and the median filter.
interface median_filter_if;
  import median_filter_pkg::*;

  pixel_t pixel_in1;
  pixel_t pixel_in2;
  pixel_t pixel_in3;
  logic   enable;
  pixel_t pixel_out;
  logic   readable;

  modport master (
    output pixel_in1, pixel_in2, pixel_in3, enable,
    input  pixel_out, readable
  );

  modport slave (
    input  pixel_in1, pixel_in2, pixel_in3, enable,
    output pixel_out, readable
  );
endinterface

// File: rtl/median_sort3.sv
// Three-input sorting network of three compare-exchanges: min / median / max.
module median_sort3
  import median_filter_pkg::*;
(
  input  pixel_t a_i,
  input  pixel_t b_i,
  input  pixel_t c_i,
  output pixel_t lo_o,
  output pixel_t mid_o,
  output pixel_t hi_o
);
  pixel_t x_lo, x_hi, y_lo;

  always_comb begin
    x_lo  = (a_i  < b_i)  ? a_i  : b_i;
    x_hi  = (a_i  < b_i)  ? b_i  : a_i;
    y_lo  = (x_hi < c_i)  ? x_hi : c_i;
    hi_o  = (x_hi < c_i)  ? c_i  : x_hi;
    lo_o  = (x_lo < y_lo) ? x_lo : y_lo;
    mid_o = (x_lo < y_lo) ? y_lo : x_lo;
  end
endmodule

// File: rtl/median_filter.sv
// 3x3 median over the last three columns; window shifts every clock, median is combinational
// from the window registers, readable is enable delayed by one edge.
module median_filter
  import median_filter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  median_filter_if.slave  bus
);
  col_t [COLS-1:0] win_q, win_d;
  logic            rdy_q;
  col_t            col_in;

  assign col_in = {bus.pixel_in1, bus.pixel_in2, bus.pixel_in3};

  // Index 0 is the newest column; the oldest falls off the top.
  always_comb begin
    win_d = {win_q[COLS-2:0], col_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      win_q <= win_d;
      rdy_q <= bus.enable;
    end
  end

  pixel_t [COLS-1:0] c_lo, c_mid, c_hi;

  for (genvar g = 0; g < COLS; g++) begin : g_col
    median_sort3 u_sort (
      .a_i  (win_q[g][0]),
      .b_i  (win_q[g][1]),
      .c_i  (win_q[g][2]),
      .lo_o (c_lo[g]),
      .mid_o(c_mid[g]),
      .hi_o (c_hi[g])
    );
  end

  // Median of nine = median(max of column mins, median of column medians, min of column maxes).
  pixel_t max_lo, med_mid, min_hi;
  pixel_t lo_a, lo_b, mi_a, mi_b, hi_a, hi_b, fin_a, fin_b;

  median_sort3 u_grp_lo (.a_i(c_lo[0]),  .b_i(c_lo[1]),  .c_i(c_lo[2]),
                         .lo_o(lo_a),   .mid_o(lo_b),    .hi_o(max_lo));
  median_sort3 u_grp_mid(.a_i(c_mid[0]), .b_i(c_mid[1]), .c_i(c_mid[2]),
                         .lo_o(mi_a),   .mid_o(med_mid), .hi_o(mi_b));
  median_sort3 u_grp_hi (.a_i(c_hi[0]),  .b_i(c_hi[1]),  .c_i(c_hi[2]),
                         .lo_o(min_hi), .mid_o(hi_a),    .hi_o(hi_b));
  median_sort3 u_final  (.a_i(max_lo),   .b_i(med_mid),  .c_i(min_hi),
                         .lo_o(fin_a),  .mid_o(bus.pixel_out), .hi_o(fin_b));

  logic unused_grp;
  assign unused_grp = ^{lo_a, lo_b, mi_a, mi_b, hi_a, hi_b, fin_a, fin_b};

  assign bus.readable = rdy_q;
endmodule

// File: tb/tb_median_filter.sv
// Streams columns into median_filter; a 9-value sort model feeds a queue of expected medians.
module tb_median_filter;
  logic clk = 1'b0;
  logic reset;

  median_filter_if bus();

  median_filter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int out_cnt = 0;
  int exp_q[$];
  int mw[9];

  function automatic int med9();
    int v[9];
    int tmp;
    for (int i = 0; i < 9; i++) v[i] = mw[i];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
        end
    return v[4];
  endfunction

  // Drive one column ahead of the edge, update the model window, return just after the next negedge.
  task automatic step(input int t, input int m, input int b, input bit en);
    bus.pixel_in1 = 5'(t);
    bus.pixel_in2 = 5'(m);
    bus.pixel_in3 = 5'(b);
    bus.enable    = en;
    for (int i = 8; i >= 3; i--) mw[i] = mw[i-3];
    mw[0] = t; mw[1] = m; mw[2] = b;
    if (en) exp_q.push_back(med9());
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int e;
    if (reset && bus.readable) begin
      checks++;
      out_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: pixel_out=%0d with no expected value queued", bus.pixel_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.pixel_out !== e[4:0]) begin
          errors++;
          $display("FAIL scoreboard_median: pixel_out=%0d expected=%0d", bus.pixel_out, e);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    bus.pixel_in1 = '0; bus.pixel_in2 = '0; bus.pixel_in3 = '0; bus.enable = 1'b0;
    for (int i = 0; i < 9; i++) mw[i] = 0;
    #1;
    checks++;
    if (bus.readable !== 1'b0 || bus.pixel_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: readable=%b pixel_out=%0d expected 0/0", bus.readable, bus.pixel_out);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    step(9, 9, 9, 1'b0);
    step(9, 9, 9, 1'b0);
    step(9, 9, 9, 1'b1);
    checks++;
    if (bus.readable !== 1'b1 || bus.pixel_out !== 5'd9) begin
      errors++;
      $display("FAIL pre_reset_window: readable=%b pixel_out=%0d expected 1/9", bus.readable, bus.pixel_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.readable !== 1'b0 || bus.pixel_out !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: readable=%b pixel_out=%0d expected 0/0", bus.readable, bus.pixel_out);
    end
    bus.pixel_in1 = '0; bus.pixel_in2 = '0; bus.pixel_in3 = '0; bus.enable = 1'b0;
    for (int i = 0; i < 9; i++) mw[i] = 0;
    exp_q.delete();
    #1;
    reset = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_constant();
    int start = out_cnt;
    for (int i = 0; i < 5; i++) begin
      step(7, 7, 7, i >= 2);
      checks++;
      if (bus.readable !== (i >= 2)) begin
        errors++;
        $display("FAIL const_readable col%0d: readable=%b expected %b", i, bus.readable, i >= 2);
      end
    end
    checks++;
    if (out_cnt - start != 3) begin
      errors++;
      $display("FAIL const_count: outputs=%0d expected 3", out_cnt - start);
    end
  endtask

  task automatic test_ramp();
    step(0, 1, 2, 1'b0);
    step(3, 4, 5, 1'b0);
    step(6, 7, 8, 1'b1);
    checks++;
    if (bus.pixel_out !== 5'd4) begin
      errors++;
      $display("FAIL ramp_median: pixel_out=%0d expected 4", bus.pixel_out);
    end
    step(8, 3, 1, 1'b0);
    step(0, 7, 5, 1'b0);
    step(4, 2, 6, 1'b1);
    checks++;
    if (bus.pixel_out !== 5'd4) begin
      errors++;
      $display("FAIL ramp_permuted: pixel_out=%0d expected 4", bus.pixel_out);
    end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 7; i++) begin
      step(0, (i == 3) ? 31 : 0, 0, i >= 2);
      if (i >= 2) begin
        checks++;
        if (bus.pixel_out !== 5'd0) begin
          errors++;
          $display("FAIL impulse col%0d: pixel_out=%0d expected 0", i, bus.pixel_out);
        end
      end
    end
  endtask

  task automatic test_random_stream();
    int start = out_cnt;
    int gaps = 0;
    for (int i = 0; i < 102; i++) begin
      step($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), i >= 2);
      if (i >= 2 && bus.readable !== 1'b1) gaps++;
    end
    checks++;
    if (out_cnt - start != 100 || gaps != 0) begin
      errors++;
      $display("FAIL random_stream: outputs=%0d gaps=%0d expected 100/0", out_cnt - start, gaps);
    end
  endtask

  task automatic test_enable_drop();
    int lows = 0;
    bit en;
    for (int i = 0; i < 12; i++) begin
      en = (i >= 2) && (i != 6) && (i != 7);
      step($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), en);
      checks++;
      if (bus.readable !== en) begin
        errors++;
        $display("FAIL drop_readable col%0d: readable=%b expected %b", i, bus.readable, en);
      end
      if (i >= 2 && bus.readable !== 1'b1) lows++;
    end
    checks++;
    if (lows != 2) begin
      errors++;
      $display("FAIL drop_low_cycles: low=%0d expected 2", lows);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_impulse();
    test_random_stream();
    test_enable_drop();
    bus.enable = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expected values never produced", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
